// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Receive-side VGA timing decoder. Watches hsync/vsync on the pixel clock,
// rebuilds the transmitter's pixel/line position, qualifies it with a lock
// state machine and reports any departure from the expected sync timing.
// h_ctr/v_ctr always describe the sample presented in the current cycle.

module vga_sync_decoder #(
    parameter int HD          = 640,
    parameter int HT          = 800,
    parameter int HSYNC_START = 656,
    parameter int HS          = 96,
    parameter int VD          = 480,
    parameter int VT          = 525,
    parameter int VSYNC_LINE  = 489,
    parameter int VSYNC_PIX   = 1,
    parameter int VS          = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] h_pos,
    output logic [9:0] v_pos,
    output logic       de,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err,
    output logic [7:0] err_cnt
);

    // Lock FSM encoding, kept as plain constants for legacy tool flows.
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] H_SYNC = 2'd1;
    localparam logic [1:0] V_SYNC = 2'd2;
    localparam logic [1:0] LOCKED = 2'd3;

    // Timing landmarks expressed at counter width.
    localparam logic [9:0] H_LAST      = 10'(HT - 1);
    localparam logic [9:0] H_ACT       = 10'(HD);
    localparam logic [9:0] H_FALL      = 10'(HSYNC_START);
    localparam logic [9:0] H_LOAD      = 10'(HSYNC_START + 1);
    localparam logic [9:0] H_RISE      = 10'(HSYNC_START + HS);
    localparam logic [9:0] V_LAST      = 10'(VT - 1);
    localparam logic [9:0] V_ACT       = 10'(VD);
    localparam logic [9:0] V_FALL      = 10'(VSYNC_LINE);
    localparam logic [9:0] V_LOAD_WRAP = 10'(VSYNC_LINE + 1);
    localparam logic [9:0] V_RISE      = 10'(VSYNC_LINE + VS);
    localparam logic [9:0] V_PIX       = 10'(VSYNC_PIX);
    localparam logic [3:0] LOCK_TGT    = 4'(LOCK_FRAMES);

    logic       hs_q;
    logic       vs_q;
    logic       hfall;
    logic       hrise;
    logic       vfall;
    logic       vrise;
    logic [9:0] h_ctr;
    logic [9:0] v_ctr;
    logic       h_wrap;
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] good_cnt;
    logic [3:0] good_nxt;
    logic       h_chk;
    logic       v_chk;
    logic       h_err;
    logic       v_err;
    logic       any_err;
    logic       pos_valid;
    logic       in_active;

    // Previous-sample registers for sync edge detection (idle level is high).
    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // and pclk alone is in the sensitivity list.
    always_ff @(posedge pclk) begin
        if (reset) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every register updating
            // from the same pre-edge values regardless of statement order.
            hs_q <= hsync;
            vs_q <= vsync;
        end
    end

    assign hfall  = hs_q & ~hsync;
    assign hrise  = ~hs_q & hsync;
    assign vfall  = vs_q & ~vsync;
    assign vrise  = ~vs_q & vsync;
    assign h_wrap = (h_ctr == H_LAST);

    // Pixel counter: free-runs across the line, realigned by each hsync fall.
    always_ff @(posedge pclk) begin
        if (reset) begin
            h_ctr <= 10'd0;
        end else if (hfall) begin
            h_ctr <= H_LOAD;
        end else if (h_wrap) begin
            h_ctr <= 10'd0;
        end else begin
            h_ctr <= h_ctr + 10'd1;
        end
    end

    // Line counter: steps on line wrap, realigned by each vsync fall. A fall
    // seen on the last pixel of a line belongs to the following line.
    always_ff @(posedge pclk) begin
        if (reset) begin
            v_ctr <= 10'd0;
        end else if (vfall) begin
            v_ctr <= h_wrap ? V_LOAD_WRAP : V_FALL;
        end else if (h_wrap) begin
            v_ctr <= (v_ctr == V_LAST) ? 10'd0 : v_ctr + 10'd1;
        end
    end

    // Timing checks: each sync edge must appear exactly where the counters
    // predict, and a predicted edge that does not appear is equally an error.
    always_comb begin
        h_chk   = (state != SEARCH);
        v_chk   = (state == V_SYNC) || (state == LOCKED);
        h_err   = h_chk && ((hfall != (h_ctr == H_FALL)) ||
                            (hrise != (h_ctr == H_RISE)));
        v_err   = v_chk && ((vfall != ((v_ctr == V_FALL) && (h_ctr == V_PIX))) ||
                            (vrise != ((v_ctr == V_RISE) && (h_ctr == V_PIX))));
        any_err = h_err | v_err;
    end

    // Lock FSM next-state and good-frame counting.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        good_nxt  = good_cnt;
        case (state)
            SEARCH: begin
                if (hfall) begin
                    state_nxt = H_SYNC;
                end
            end
            H_SYNC: begin
                if (any_err) begin
                    state_nxt = SEARCH;
                end else if (vfall) begin
                    state_nxt = V_SYNC;
                    good_nxt  = 4'd0;
                end
            end
            V_SYNC: begin
                if (any_err) begin
                    state_nxt = SEARCH;
                end else if (vfall) begin
                    good_nxt = good_cnt + 4'd1;
                    if (good_nxt == LOCK_TGT) begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_nxt = SEARCH;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    // Lock FSM state and good-frame counter registers.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state    <= SEARCH;
            good_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // Registered status: lock flag, frame marker, error pulse and tally.
    always_ff @(posedge pclk) begin
        if (reset) begin
            locked      <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            locked      <= (state_nxt == LOCKED);
            frame_start <= (state == LOCKED) && (h_ctr == 10'd0) && (v_ctr == 10'd0);
            sync_err    <= any_err;
            if (any_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Position outputs: only meaningful once vertical alignment exists, and
    // only inside the active picture.
    always_comb begin
        pos_valid = (state == V_SYNC) || (state == LOCKED);
        in_active = (h_ctr < H_ACT) && (v_ctr < V_ACT);
        h_pos     = (pos_valid && in_active) ? h_ctr : 10'd0;
        v_pos     = (pos_valid && in_active) ? v_ctr : 10'd0;
        de        = locked && in_active;
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
// Directed bench for vga_sync_decoder using a shrunk video timing so whole
// frames fit in a short run. A behavioural sync source plays clean frames
// and injects specific timing faults on chosen frames/lines.

module tb_vga_sync_decoder;

    localparam int HD          = 16;
    localparam int HT          = 24;
    localparam int HSYNC_START = 18;
    localparam int HS          = 3;
    localparam int VD          = 8;
    localparam int VT          = 14;
    localparam int VSYNC_LINE  = 10;
    localparam int VSYNC_PIX   = 1;
    localparam int VS          = 2;
    localparam int LOCK_FRAMES = 2;

    logic       pclk = 1'b0;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic [9:0] h_pos;
    logic [9:0] v_pos;
    logic       de;
    logic       locked;
    logic       frame_start;
    logic       sync_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int gpix   = HT - 1;
    int gline  = VT - 1;
    int gframe = -1;
    int pulses = 0;
    int pulse_base;

    vga_sync_decoder #(
        .HD(HD), .HT(HT), .HSYNC_START(HSYNC_START), .HS(HS),
        .VD(VD), .VT(VT), .VSYNC_LINE(VSYNC_LINE), .VSYNC_PIX(VSYNC_PIX),
        .VS(VS), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .h_pos(h_pos), .v_pos(v_pos), .de(de), .locked(locked),
        .frame_start(frame_start), .sync_err(sync_err), .err_cnt(err_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the source one pixel and present that sample before the next
    // rising edge; outputs are sampled 1 ns after the falling edge.
    task automatic step();
        int idx;
        int hs_start;
        int vs_end;
        logic hs_low;
        logic vs_low;
        gpix++;
        if (gpix == HT) begin
            gpix = 0;
            gline++;
            if (gline == VT) begin
                gline = 0;
                gframe++;
            end
        end
        idx      = gline * HT + gpix;
        hs_start = (gframe == 4 && gline == 2) ? HSYNC_START - 3 : HSYNC_START;
        hs_low   = (gpix >= hs_start) && (gpix < HSYNC_START + HS);
        if (gframe == 7 && gline == 4) hs_low = 1'b0;
        if (gframe == 17 || gframe == 18) hs_low = (gpix % 2 == 0);
        vs_end   = VSYNC_LINE * HT + VSYNC_PIX + ((gframe == 10) ? 1 : VS) * HT;
        vs_low   = (idx >= VSYNC_LINE * HT + VSYNC_PIX) && (idx < vs_end);
        @(negedge pclk);
        hsync = ~hs_low;
        vsync = ~vs_low;
        #1;
        if (sync_err) pulses++;
    endtask

    task automatic run_to(input int f, input int l, input int p);
        int n = 0;
        while (!(gframe == f && gline == l && gpix == p) && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) begin
            check("run_to_timeout", gframe * 10000 + gline * 100 + gpix, f * 10000 + l * 100 + p);
        end
    endtask

    initial begin
        reset = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (3) @(negedge pclk);
        #1;
        check("rst_h_pos", h_pos, 0);
        check("rst_v_pos", v_pos, 0);
        check("rst_de", de, 0);
        check("rst_locked", locked, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        reset = 1'b0;

        // Initial acquisition: lock rises right after the third vsync fall.
        run_to(2, VSYNC_LINE, VSYNC_PIX);
        check("pre_lock", locked, 0);
        check("acq_no_err_pulse", pulses, 0);
        step();
        check("lock_rise", locked, 1);
        check("acq_err_cnt", err_cnt, 0);

        // Frame marker follows the (0,0) sample by one cycle.
        run_to(3, 0, 0);
        check("fs_before", frame_start, 0);
        step();
        check("fs_pulse", frame_start, 1);
        step();
        check("fs_after", frame_start, 0);

        // Position decode inside and outside the active area.
        run_to(3, 5, 10);
        check("act_h_pos", h_pos, 10);
        check("act_v_pos", v_pos, 5);
        check("act_de", de, 1);
        run_to(3, 5, 20);
        check("hblank_h_pos", h_pos, 0);
        check("hblank_de", de, 0);
        run_to(3, 9, 3);
        check("vblank_v_pos", v_pos, 0);
        check("vblank_de", de, 0);

        // Early hsync fall three pixels ahead of schedule.
        run_to(4, 2, HSYNC_START - 3);
        check("early_pre_err", sync_err, 0);
        step();
        check("early_sync_err", sync_err, 1);
        check("early_unlock", locked, 0);
        check("early_err_cnt", err_cnt, 1);
        step();
        check("early_pulse_end", sync_err, 0);
        run_to(6, VSYNC_LINE, VSYNC_PIX + 1);
        check("early_relock", locked, 1);
        check("early_err_cnt_hold", err_cnt, 1);
        check("early_one_pulse", pulses, 1);

        // Missing hsync for one line: flagged where the fall was due.
        run_to(7, 4, HSYNC_START + 1);
        check("miss_sync_err", sync_err, 1);
        check("miss_unlock", locked, 0);
        check("miss_err_cnt", err_cnt, 2);
        step();
        check("miss_pulse_end", sync_err, 0);
        run_to(9, VSYNC_LINE, VSYNC_PIX + 1);
        check("miss_relock", locked, 1);
        check("miss_err_cnt_hold", err_cnt, 2);
        check("miss_one_pulse", pulses, 2);

        // One-line vsync: the early rise is the violation.
        run_to(10, VSYNC_LINE + 1, VSYNC_PIX);
        check("short_pre_err", sync_err, 0);
        check("short_pre_lock", locked, 1);
        step();
        check("short_sync_err", sync_err, 1);
        check("short_unlock", locked, 0);
        check("short_err_cnt", err_cnt, 3);
        run_to(13, VSYNC_LINE, VSYNC_PIX + 1);
        check("short_relock", locked, 1);
        check("short_one_pulse", pulses, 3);

        // Mid-frame reset while locked, then clean re-acquisition.
        run_to(14, 3, 5);
        check("prerst_de", de, 1);
        check("prerst_h_pos", h_pos, 5);
        check("prerst_v_pos", v_pos, 3);
        reset = 1'b1;
        step();
        check("midrst_locked", locked, 0);
        check("midrst_de", de, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_h_pos", h_pos, 0);
        check("midrst_sync_err", sync_err, 0);
        step();
        reset = 1'b0;
        pulse_base = pulses;
        run_to(16, VSYNC_LINE, VSYNC_PIX + 1);
        check("postrst_relock", locked, 1);
        check("postrst_err_cnt", err_cnt, 0);
        check("postrst_no_pulse", pulses - pulse_base, 0);

        // Toggling hsync every pixel for two frames: 12 errors per line,
        // 336 in total, so the counter must stop at 255.
        run_to(17, 1, 0);
        check("sat_line0", err_cnt, 12);
        run_to(18, 0, 0);
        check("sat_frame0", err_cnt, 168);
        run_to(19, 0, 0);
        check("sat_full", err_cnt, 255);
        run_to(19, 3, 0);
        check("sat_hold", err_cnt, 255);
        check("sat_unlocked", locked, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
